// File: rtl/deparser_rule_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : deparser_rule_arbiter
//  Purpose  : Arbitrates rule-configuration accesses from two masters (host CSR
//             bridge on port 0, table loader on port 1) onto the deparser rule
//             bus. It uses round-robin fairness and checks the layer select in
//             addr[25:24]. It issues single-cycle write/read strobes and returns
//             a one-cycle completion pulse with error status to the requester.
//  Options  : DEPARSER_RULE_RDBACK_EN - when defined, reads are issued to the
//             deparser and wait for read data (bounded by RD_TIMEOUT). When
//             undefined, the read path is not built and every valid-layer read
//             completes immediately with an error.
//  Ports    : i_clk, i_rst_n          clock, synchronous active-low reset
//             i_reqN_*/o_reqN_ready   request ports 0 (host) and 1 (loader)
//             o_respN_valid           per-port completion pulse
//             o_resp_err/o_resp_rdata completion status / read data
//             o_rule_*                deparser rule bus strobes, addr, wdata
//             i_rule_rdata*           read data return from deparser
//             o_busy                  high whenever the FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module deparser_rule_arbiter #(
    parameter int NUM_LAYERS = 3,
    parameter int RD_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic        i_req0_wr,
    input  logic [31:0] i_req0_addr,
    input  logic [31:0] i_req0_wdata,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic        i_req1_wr,
    input  logic [31:0] i_req1_addr,
    input  logic [31:0] i_req1_wdata,
    output logic        o_resp0_valid,
    output logic        o_resp1_valid,
    output logic        o_resp_err,
    output logic [31:0] o_resp_rdata,
    output logic        o_rule_wren,
    output logic        o_rule_rden,
    output logic [31:0] o_rule_addr,
    output logic [31:0] o_rule_wdata,
    input  logic        i_rule_rdata_valid,
    input  logic [31:0] i_rule_rdata,
    output logic        o_busy
);

    localparam logic [31:0] LAYER_LIMIT = 32'(NUM_LAYERS);

`ifdef DEPARSER_RULE_RDBACK_EN
    localparam int                CNT_W   = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(RD_TIMEOUT);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
`ifdef DEPARSER_RULE_RDBACK_EN
        ST_WAIT_RD = 2'd2,
`endif
        ST_RESP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Port that won the most recent handshake; resets to 1 so port 0 wins
    // the first tie.
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic        handshake;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        layer_ok;

    logic        lat_id;
    logic        lat_wr;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        resp_err;
    logic [31:0] resp_rdata;

    logic        load_req;
    logic        set_resp;
    logic        err_next;
    logic [31:0] rdata_next;

`ifdef DEPARSER_RULE_RDBACK_EN
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_inc;
    logic             cnt_clr;
    logic             cnt_inc;
`else
    logic             unused_rdata;
    assign unused_rdata = ^{i_rule_rdata_valid, i_rule_rdata};
`endif

    // ------------------------------------------------------------------------
    // Round-robin grant: a lone requester always wins; on a tie the port
    // that was not granted last time wins.
    // ------------------------------------------------------------------------
    always_comb begin
        grant0    = i_req0_valid & (~i_req1_valid | last_grant);
        grant1    = i_req1_valid & (~i_req0_valid | ~last_grant);
        handshake = (state == ST_IDLE) & (grant0 | grant1);
        sel_wr    = grant1 ? i_req1_wr    : i_req0_wr;
        sel_addr  = grant1 ? i_req1_addr  : i_req0_addr;
        sel_wdata = grant1 ? i_req1_wdata : i_req0_wdata;
        layer_ok  = {30'd0, sel_addr[25:24]} < LAYER_LIMIT;
    end

    // Ready is forced low while reset is held so nothing is accepted then.
    assign o_req0_ready = i_rst_n & (state == ST_IDLE) & grant0;
    assign o_req1_ready = i_rst_n & (state == ST_IDLE) & grant1;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and datapath controls
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        set_resp   = 1'b0;
        err_next   = 1'b0;
        rdata_next = 32'd0;
`ifdef DEPARSER_RULE_RDBACK_EN
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        tmo_cnt_inc = tmo_cnt + CNT_W'(1);
`endif
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    load_req = 1'b1;
                    if (!layer_ok) begin
                        state_next = ST_RESP;
                        set_resp   = 1'b1;
                        err_next   = 1'b1;
                    end else if (sel_wr) begin
                        state_next = ST_ISSUE;
                    end else begin
`ifdef DEPARSER_RULE_RDBACK_EN
                        state_next = ST_ISSUE;
`else
                        // No read path: valid-layer reads fail immediately.
                        state_next = ST_RESP;
                        set_resp   = 1'b1;
                        err_next   = 1'b1;
`endif
                    end
                end
            end
            ST_ISSUE: begin
                if (lat_wr) begin
                    state_next = ST_RESP;
                    set_resp   = 1'b1;
                end else begin
`ifdef DEPARSER_RULE_RDBACK_EN
                    state_next = ST_WAIT_RD;
                    cnt_clr    = 1'b1;
`else
                    state_next = ST_RESP;
                    set_resp   = 1'b1;
                    err_next   = 1'b1;
`endif
                end
            end
`ifdef DEPARSER_RULE_RDBACK_EN
            ST_WAIT_RD: begin
                // Data arriving on the final wait cycle still beats the timeout.
                if (i_rule_rdata_valid) begin
                    state_next = ST_RESP;
                    set_resp   = 1'b1;
                    rdata_next = i_rule_rdata;
                end else if (tmo_cnt_inc == TMO_VAL) begin
                    state_next = ST_RESP;
                    set_resp   = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, round-robin pointer and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_wr     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            if (load_req) begin
                last_grant <= grant1;
                lat_id     <= grant1;
                lat_wr     <= sel_wr;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
            end
            if (set_resp) begin
                resp_err   <= err_next;
                resp_rdata <= rdata_next;
            end
        end
    end

`ifdef DEPARSER_RULE_RDBACK_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (cnt_clr) begin
            tmo_cnt <= '0;
        end else if (cnt_inc) begin
            tmo_cnt <= tmo_cnt_inc;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_rule_wren  = (state == ST_ISSUE) & lat_wr;
`ifdef DEPARSER_RULE_RDBACK_EN
    assign o_rule_rden  = (state == ST_ISSUE) & ~lat_wr;
`else
    assign o_rule_rden  = 1'b0;
`endif
    assign o_rule_addr   = lat_addr;
    assign o_rule_wdata  = lat_wdata;
    assign o_resp0_valid = (state == ST_RESP) & ~lat_id;
    assign o_resp1_valid = (state == ST_RESP) & lat_id;
    assign o_resp_err    = (state == ST_RESP) & resp_err;
    assign o_resp_rdata  = (state == ST_RESP) ? resp_rdata : 32'd0;
    assign o_busy        = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_deparser_rule_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deparser_rule_arbiter
//  Purpose  : Directed self-checking bench for deparser_rule_arbiter. Inputs
//             change on the falling edge and outputs are sampled there too.
//             Expectations follow the build option DEPARSER_RULE_RDBACK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_deparser_rule_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_wr;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_wr;
    logic [31:0] req1_addr, req1_wdata;
    logic        resp0_valid, resp1_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        rule_wren, rule_rden;
    logic [31:0] rule_addr, rule_wdata;
    logic        rule_rdata_valid;
    logic [31:0] rule_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    deparser_rule_arbiter #(.NUM_LAYERS(3), .RD_TIMEOUT(16)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req0_valid       (req0_valid),
        .o_req0_ready       (req0_ready),
        .i_req0_wr          (req0_wr),
        .i_req0_addr        (req0_addr),
        .i_req0_wdata       (req0_wdata),
        .i_req1_valid       (req1_valid),
        .o_req1_ready       (req1_ready),
        .i_req1_wr          (req1_wr),
        .i_req1_addr        (req1_addr),
        .i_req1_wdata       (req1_wdata),
        .o_resp0_valid      (resp0_valid),
        .o_resp1_valid      (resp1_valid),
        .o_resp_err         (resp_err),
        .o_resp_rdata       (resp_rdata),
        .o_rule_wren        (rule_wren),
        .o_rule_rden        (rule_rden),
        .o_rule_addr        (rule_addr),
        .o_rule_wdata       (rule_wdata),
        .i_rule_rdata_valid (rule_rdata_valid),
        .i_rule_rdata       (rule_rdata),
        .o_busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        req0_valid = 1'b1; req0_wr = 1'b1;
        req1_valid = 1'b1; req1_wr = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rule_wren !== 1'b0 || rule_rden !== 1'b0) begin bad++; $display("FAIL reset_strobes: got %b%b want 00", rule_wren, rule_rden); end
        total++; if (rule_addr !== 32'd0 || rule_wdata !== 32'd0) begin bad++; $display("FAIL reset_rule_bus: got %h/%h want 0/0", rule_addr, rule_wdata); end
        total++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b%b want 00", resp0_valid, resp1_valid); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    // Both ports continuously request writes: grants 0,1,0,1 with one strobe every 3 cycles.
    task automatic test_back_to_back();
        logic        exp_r0, exp_r1, exp_wr, exp_p0, exp_p1;
        logic [31:0] exp_a, exp_d;
        int          wren_cnt;
        wren_cnt = 0;
        req0_wr = 1'b1; req0_addr = 32'h0000_0100; req0_wdata = 32'h0000_00A0;
        req1_wr = 1'b1; req1_addr = 32'h0100_0200; req1_wdata = 32'h0000_00B1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            exp_r0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            exp_r1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            exp_wr = (c % 3 == 1);
            exp_p0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            exp_p1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
            exp_a  = ((c / 3) % 2 == 0) ? 32'h0000_0100 : 32'h0100_0200;
            exp_d  = ((c / 3) % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1;
            if (rule_wren === 1'b1) wren_cnt++;
            total++; if (req0_ready !== exp_r0 || req1_ready !== exp_r1) begin bad++; $display("FAIL b2b_ready c=%0d: got %b%b want %b%b", c, req0_ready, req1_ready, exp_r0, exp_r1); end
            total++; if (rule_wren !== exp_wr) begin bad++; $display("FAIL b2b_wren c=%0d: got %b want %b", c, rule_wren, exp_wr); end
            if (exp_wr) begin
                total++; if (rule_addr !== exp_a || rule_wdata !== exp_d) begin bad++; $display("FAIL b2b_bus c=%0d: got %h/%h want %h/%h", c, rule_addr, rule_wdata, exp_a, exp_d); end
            end
            total++; if (resp0_valid !== exp_p0 || resp1_valid !== exp_p1) begin bad++; $display("FAIL b2b_resp c=%0d: got %b%b want %b%b", c, resp0_valid, resp1_valid, exp_p0, exp_p1); end
            if (c == 11) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            step();
        end
        total++; if (wren_cnt != 4) begin bad++; $display("FAIL b2b_wren_count: got %0d want 4", wren_cnt); end
    endtask

    task automatic test_write();
        req0_wr = 1'b1; req0_addr = 32'h0100_0004; req0_wdata = 32'hA5A5_0001;
        req0_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL wr_ready: got %b%b want 10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        total++; if (rule_wren !== 1'b1 || rule_rden !== 1'b0) begin bad++; $display("FAIL wr_strobe: got %b%b want 10", rule_wren, rule_rden); end
        total++; if (rule_addr !== 32'h0100_0004 || rule_wdata !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_bus: got %h/%h want 01000004/a5a50001", rule_addr, rule_wdata); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", busy); end
        step();
        total++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL wr_resp: got v%b%b e%b want v10 e0", resp0_valid, resp1_valid, resp_err); end
        total++; if (rule_wren !== 1'b0) begin bad++; $display("FAIL wr_strobe_len: got %b want 0", rule_wren); end
        step();
        total++; if (resp0_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_idle: got resp %b busy %b want 0 0", resp0_valid, busy); end
        total++; if (rule_addr !== 32'h0100_0004) begin bad++; $display("FAIL wr_addr_hold: got %h want 01000004", rule_addr); end
    endtask

    task automatic test_invalid_layer();
        req0_wr = 1'b1; req0_addr = 32'h0300_0000; req0_wdata = 32'h0000_0077;
        req0_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bad_layer_ready: got %b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        total++; if (rule_wren !== 1'b0 || rule_rden !== 1'b0) begin bad++; $display("FAIL bad_layer_strobe: got %b%b want 00", rule_wren, rule_rden); end
        total++; if (resp0_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin bad++; $display("FAIL bad_layer_resp: got v%b e%b d%h want v1 e1 d0", resp0_valid, resp_err, resp_rdata); end
        step();
        total++; if (resp0_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bad_layer_idle: got resp %b busy %b want 0 0", resp0_valid, busy); end
    endtask

    task automatic test_read();
        req1_wr = 1'b0; req1_addr = 32'h0200_0010; req1_wdata = 32'd0;
        req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL rd_ready: got %b%b want 01", req0_ready, req1_ready); end
        step();
        req1_valid = 1'b0;
`ifdef DEPARSER_RULE_RDBACK_EN
        total++; if (rule_rden !== 1'b1 || rule_wren !== 1'b0 || rule_addr !== 32'h0200_0010) begin bad++; $display("FAIL rd_strobe: got r%b w%b a%h want r1 w0 a02000010", rule_rden, rule_wren, rule_addr); end
        step();
        total++; if (rule_rden !== 1'b0 || resp1_valid !== 1'b0) begin bad++; $display("FAIL rd_wait: got rden %b resp %b want 0 0", rule_rden, resp1_valid); end
        step();
        rule_rdata_valid = 1'b1;
        rule_rdata       = 32'h1234_5678;
        total++; if (resp1_valid !== 1'b0) begin bad++; $display("FAIL rd_early_resp: got %b want 0", resp1_valid); end
        step();
        rule_rdata_valid = 1'b0;
        rule_rdata       = 32'd0;
        total++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_resp: got v%b%b e%b d%h want v01 e0 d12345678", resp0_valid, resp1_valid, resp_err, resp_rdata); end
`else
        total++; if (rule_rden !== 1'b0 || rule_wren !== 1'b0) begin bad++; $display("FAIL rd_nostrobe: got r%b w%b want 00", rule_rden, rule_wren); end
        total++; if (resp1_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin bad++; $display("FAIL rd_resp: got v%b e%b d%h want v1 e1 d0", resp1_valid, resp_err, resp_rdata); end
`endif
        step();
        total++; if (busy !== 1'b0 || resp1_valid !== 1'b0) begin bad++; $display("FAIL rd_idle: got busy %b resp %b want 0 0", busy, resp1_valid); end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        req0_wr = 1'b0; req0_addr = 32'h0000_0020;
        req0_valid = 1'b1;
`ifndef DEPARSER_RULE_RDBACK_EN
        // Read data offered anyway must be ignored without the read path.
        rule_rdata_valid = 1'b1;
        rule_rdata       = 32'hDEAD_BEEF;
`endif
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL tmo_ready: got %b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
`ifdef DEPARSER_RULE_RDBACK_EN
        total++; if (rule_rden !== 1'b1) begin bad++; $display("FAIL tmo_rden: got %b want 1", rule_rden); end
        for (int k = 2; k <= 17; k++) begin
            step();
            if (resp0_valid !== 1'b0 || busy !== 1'b1) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL tmo_early: got %0d bad wait cycles want 0", early); end
        step();
        total++; if (resp0_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin bad++; $display("FAIL tmo_resp: got v%b e%b d%h want v1 e1 d0", resp0_valid, resp_err, resp_rdata); end
`else
        total++; if (resp0_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin bad++; $display("FAIL tmo_resp: got v%b e%b d%h want v1 e1 d0", resp0_valid, resp_err, resp_rdata); end
        rule_rdata_valid = 1'b0;
        rule_rdata       = 32'd0;
`endif
        step();
        // A following write must proceed normally.
        req1_wr = 1'b1; req1_addr = 32'h0200_0040; req1_wdata = 32'h5A5A_0002;
        req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL post_tmo_ready: got %b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        total++; if (rule_wren !== 1'b1 || rule_addr !== 32'h0200_0040 || rule_wdata !== 32'h5A5A_0002) begin bad++; $display("FAIL post_tmo_wr: got w%b a%h d%h want w1 a02000040 d5a5a0002", rule_wren, rule_addr, rule_wdata); end
        step();
        total++; if (resp1_valid !== 1'b1 || resp_err !== 1'b0) begin bad++; $display("FAIL post_tmo_resp: got v%b e%b want v1 e0", resp1_valid, resp_err); end
        step();
    endtask

    task automatic test_reset_midflight();
        req0_addr = 32'h0100_0000; req0_wdata = 32'h0000_0011;
`ifdef DEPARSER_RULE_RDBACK_EN
        req0_wr = 1'b0;
`else
        req0_wr = 1'b1;
`endif
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
`ifdef DEPARSER_RULE_RDBACK_EN
        step();
`endif
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        step();
        total++; if (busy !== 1'b0 || rule_wren !== 1'b0 || rule_rden !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl: got busy %b w%b r%b want 0 0 0", busy, rule_wren, rule_rden); end
        total++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin bad++; $display("FAIL mid_rst_resp: got v%b%b e%b d%h want all 0", resp0_valid, resp1_valid, resp_err, resp_rdata); end
        total++; if (rule_addr !== 32'd0 || rule_wdata !== 32'd0) begin bad++; $display("FAIL mid_rst_bus: got %h/%h want 0/0", rule_addr, rule_wdata); end
        step();
        total++; if (resp0_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_noresp: got resp %b busy %b want 0 0", resp0_valid, busy); end
        rst_n = 1'b1;
        req0_wr = 1'b1; req0_addr = 32'h0000_0300; req0_wdata = 32'h0000_0033;
        req1_wr = 1'b1; req1_addr = 32'h0100_0400; req1_wdata = 32'h0000_0044;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL mid_tie: got %b%b want 10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++; if (rule_wren !== 1'b1 || rule_addr !== 32'h0000_0300) begin bad++; $display("FAIL mid_new_wr: got w%b a%h want w1 a00000300", rule_wren, rule_addr); end
        step();
        total++; if (resp0_valid !== 1'b1 || resp_err !== 1'b0) begin bad++; $display("FAIL mid_new_resp: got v%b e%b want v1 e0", resp0_valid, resp_err); end
        step();
    endtask

    initial begin
        rst_n            = 1'b0;
        req0_valid       = 1'b0; req0_wr = 1'b0; req0_addr = 32'd0; req0_wdata = 32'd0;
        req1_valid       = 1'b0; req1_wr = 1'b0; req1_addr = 32'd0; req1_wdata = 32'd0;
        rule_rdata_valid = 1'b0;
        rule_rdata       = 32'd0;
        test_reset();
        test_back_to_back();
        test_write();
        test_invalid_layer();
        test_read();
        test_timeout();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
